// File: rtl/ysyx_25020037_axi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ysyx_25020037_axi_arbiter
// Purpose  : Two-master / one-slave AXI4 arbiter. It shares the core's single
//            memory port between the IFU (M0, read-only) and the LSU (M1,
//            read and write). Only one transaction is outstanding at a time.
//            A grant is held from the address handshake to the final response.
// Options  : YSYX_25020037_ARB_RR_EN - round-robin between the two readers.
//            When undefined, M1 reads have fixed priority over M0 reads.
//            An M1 write always wins.
// Ports    : clk, rst (asynchronous, active-high)
//            m0_ar*/m0_r*        IFU read channels
//            m1_ar*/m1_r*        LSU read channels
//            m1_aw*/m1_w*/m1_b*  LSU write channels
//            s_*                 slave-side mirror of all five channels
//            grant               00 none, 01 M0 read, 10 M1 read, 11 M1 write
//            busy                grant != 00
// Buses    : ar/aw {addr, id, len[7:0], size[2:0], burst[1:0]}
//            r     {data, resp[1:0], last, id}
//            w     {data, strb, last}
//            b     {resp[1:0], id}
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020037_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  // M0 (IFU) read
  input  logic                       m0_arvalid,
  output logic                       m0_arready,
  input  logic [ADDR_W+ID_W+12:0]    m0_ar_bus,
  output logic                       m0_rvalid,
  input  logic                       m0_rready,
  output logic [DATA_W+ID_W+2:0]     m0_r_bus,
  // M1 (LSU) read
  input  logic                       m1_arvalid,
  output logic                       m1_arready,
  input  logic [ADDR_W+ID_W+12:0]    m1_ar_bus,
  output logic                       m1_rvalid,
  input  logic                       m1_rready,
  output logic [DATA_W+ID_W+2:0]     m1_r_bus,
  // M1 (LSU) write
  input  logic                       m1_awvalid,
  output logic                       m1_awready,
  input  logic [ADDR_W+ID_W+12:0]    m1_aw_bus,
  input  logic                       m1_wvalid,
  output logic                       m1_wready,
  input  logic [DATA_W+DATA_W/8:0]   m1_w_bus,
  output logic                       m1_bvalid,
  input  logic                       m1_bready,
  output logic [ID_W+1:0]            m1_b_bus,
  // Slave side
  output logic                       s_arvalid,
  input  logic                       s_arready,
  output logic [ADDR_W+ID_W+12:0]    s_ar_bus,
  input  logic                       s_rvalid,
  output logic                       s_rready,
  input  logic [DATA_W+ID_W+2:0]     s_r_bus,
  output logic                       s_awvalid,
  input  logic                       s_awready,
  output logic [ADDR_W+ID_W+12:0]    s_aw_bus,
  output logic                       s_wvalid,
  input  logic                       s_wready,
  output logic [DATA_W+DATA_W/8:0]   s_w_bus,
  input  logic                       s_bvalid,
  output logic                       s_bready,
  input  logic [ID_W+1:0]            s_b_bus,
  // Status
  output logic [1:0]                 grant,
  output logic                       busy
);

  // State encoding doubles as the grant code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    M0_RD = 2'b01,
    M1_RD = 2'b10,
    M1_WR = 2'b11
  } state_t;

  state_t state, state_nx;
  state_t rd_tie;          // winner when both readers request together
  logic   addr_done, addr_done_nx;
  logic   s_rlast;

  // rlast sits just above the rid field in the r bus.
  assign s_rlast = s_r_bus[ID_W];

  assign grant = state;
  assign busy  = (state != IDLE);

`ifdef YSYX_25020037_ARB_RR_EN
  // Last read winner: 0 = M0, 1 = M1. The loser of the previous read tie
  // is favoured next time.
  logic last_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rd <= 1'b0;
    end else if (state == IDLE && state_nx == M1_RD) begin
      last_rd <= 1'b1;
    end else if (state == IDLE && state_nx == M0_RD) begin
      last_rd <= 1'b0;
    end
  end

  assign rd_tie = last_rd ? M0_RD : M1_RD;
`else
  assign rd_tie = M1_RD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_done <= 1'b0;
    end else begin
      state     <= state_nx;
      addr_done <= addr_done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    addr_done_nx = addr_done;
    s_arvalid    = 1'b0;
    s_ar_bus     = '0;
    s_rready     = 1'b0;
    s_awvalid    = 1'b0;
    s_aw_bus     = '0;
    s_wvalid     = 1'b0;
    s_w_bus      = '0;
    s_bready     = 1'b0;
    m0_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m0_r_bus     = '0;
    m1_arready   = 1'b0;
    m1_rvalid    = 1'b0;
    m1_r_bus     = '0;
    m1_awready   = 1'b0;
    m1_wready    = 1'b0;
    m1_bvalid    = 1'b0;
    m1_b_bus     = '0;

    case (state)
      IDLE: begin
        addr_done_nx = 1'b0;
        if (m1_awvalid) begin
          state_nx = M1_WR;
        end else if (m1_arvalid && m0_arvalid) begin
          state_nx = rd_tie;
        end else if (m1_arvalid) begin
          state_nx = M1_RD;
        end else if (m0_arvalid) begin
          state_nx = M0_RD;
        end
      end

      M0_RD: begin
        // Address is offered only until the first handshake of this grant.
        s_arvalid  = m0_arvalid & ~addr_done;
        s_ar_bus   = m0_ar_bus;
        m0_arready = s_arready & ~addr_done;
        s_rready   = m0_rready;
        m0_rvalid  = s_rvalid;
        m0_r_bus   = s_r_bus;
        if (m0_arvalid && s_arready && !addr_done) begin
          addr_done_nx = 1'b1;
        end
        if (s_rvalid && m0_rready && s_rlast) begin
          state_nx     = IDLE;
          addr_done_nx = 1'b0;
        end
      end

      M1_RD: begin
        s_arvalid  = m1_arvalid & ~addr_done;
        s_ar_bus   = m1_ar_bus;
        m1_arready = s_arready & ~addr_done;
        s_rready   = m1_rready;
        m1_rvalid  = s_rvalid;
        m1_r_bus   = s_r_bus;
        if (m1_arvalid && s_arready && !addr_done) begin
          addr_done_nx = 1'b1;
        end
        if (s_rvalid && m1_rready && s_rlast) begin
          state_nx     = IDLE;
          addr_done_nx = 1'b0;
        end
      end

      M1_WR: begin
        s_awvalid  = m1_awvalid & ~addr_done;
        s_aw_bus   = m1_aw_bus;
        m1_awready = s_awready & ~addr_done;
        s_wvalid   = m1_wvalid;
        s_w_bus    = m1_w_bus;
        m1_wready  = s_wready;
        s_bready   = m1_bready;
        m1_bvalid  = s_bvalid;
        m1_b_bus   = s_b_bus;
        if (m1_awvalid && s_awready && !addr_done) begin
          addr_done_nx = 1'b1;
        end
        if (s_bvalid && m1_bready) begin
          state_nx     = IDLE;
          addr_done_nx = 1'b0;
        end
      end

      default: begin
        state_nx     = IDLE;
        addr_done_nx = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25020037_axi_arbiter
// Purpose  : Self-checking bench for ysyx_25020037_axi_arbiter. The bench
//            plays both masters and the slave. A transaction-level model
//            predicts the order in which pending requests are served.
//            Each grant is then driven end to end and every channel is
//            checked as it is routed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020037_axi_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int AX_W   = ADDR_W + ID_W + 13;
  localparam int R_W    = DATA_W + ID_W + 3;
  localparam int W_W    = DATA_W + DATA_W / 8 + 1;
  localparam int B_W    = ID_W + 2;

  logic clk = 1'b0;
  logic rst;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [AX_W-1:0] m0_ar_bus;
  logic [R_W-1:0]  m0_r_bus;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [AX_W-1:0] m1_ar_bus;
  logic [R_W-1:0]  m1_r_bus;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [AX_W-1:0] m1_aw_bus;
  logic [W_W-1:0]  m1_w_bus;
  logic [B_W-1:0]  m1_b_bus;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [AX_W-1:0] s_ar_bus, s_aw_bus;
  logic [R_W-1:0]  s_r_bus;
  logic [W_W-1:0]  s_w_bus;
  logic [B_W-1:0]  s_b_bus;
  logic [1:0]      grant;
  logic            busy;

  ysyx_25020037_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar_bus(m0_ar_bus),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_r_bus(m0_r_bus),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar_bus(m1_ar_bus),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_r_bus(m1_r_bus),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_aw_bus(m1_aw_bus),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_w_bus(m1_w_bus),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_b_bus(m1_b_bus),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar_bus(s_ar_bus),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r_bus(s_r_bus),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw_bus(s_aw_bus),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w_bus(s_w_bus),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b_bus(s_b_bus),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int order[$];     // predicted grant codes, in service order
  bit last_rd_m;    // model: last read winner, 0 = M0, 1 = M1

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive just after the rising edge; sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [AX_W-1:0] mk_ax(input logic [31:0] addr, input logic [3:0] id,
                                            input logic [7:0] len);
    return {addr, id, len, 3'b010, 2'b01};
  endfunction

  // Everything a master not holding the grant could see; it must all be 0.
  function automatic logic [7:0] other(input logic [1:0] g);
    case (g)
      2'd1:    return {1'b0, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
                       |m1_r_bus, |m1_b_bus};
      2'd2:    return {1'b0, m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid,
                       |m0_r_bus, |m1_b_bus};
      2'd3:    return {2'b0, m0_arready, m0_rvalid, m1_arready, m1_rvalid,
                       |m0_r_bus, |m1_r_bus};
      default: return 8'h0;
    endcase
  endfunction

  function automatic logic axready(input logic [1:0] g);
    return (g == 2'd1) ? m0_arready : (g == 2'd2) ? m1_arready : m1_awready;
  endfunction

  function automatic logic [12:0] idle_vec();
    return {busy, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready,
            m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
  endfunction

  // Service order for requests all pending in the same idle cycle:
  // a write first, then reads (M1 before M0, or alternating under round-robin).
  function automatic void plan(input bit w1, input bit r1, input bit r0);
    order.delete();
    if (w1) order.push_back(3);
    if (r1 && r0) begin
`ifdef YSYX_25020037_ARB_RR_EN
      if (last_rd_m) begin order.push_back(1); order.push_back(2); end
      else           begin order.push_back(2); order.push_back(1); end
`else
      order.push_back(2);
      order.push_back(1);
`endif
    end else if (r1) begin
      order.push_back(2);
    end else if (r0) begin
      order.push_back(1);
    end
  endfunction

  task automatic drive_idle_inputs();
    m0_arvalid = 0; m0_rready = 0; m0_ar_bus = '0;
    m1_arvalid = 0; m1_rready = 0; m1_ar_bus = '0;
    m1_awvalid = 0; m1_aw_bus = '0; m1_wvalid = 0; m1_w_bus = '0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_r_bus = '0; s_awready = 0;
    s_wready = 0; s_bvalid = 0; s_b_bus = '0;
  endtask

  // Carry one granted transaction from its first granted cycle to release.
  task automatic run_txn(input logic [1:0] g, input logic [AX_W-1:0] ax, input logic [1:0] resp,
                         input logic [3:0] strb, input logic [DATA_W-1:0] dseed, input bit late);
    int beats, got;
    bit done, rdy, v, raised;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] d;
    logic [R_W-1:0]    rexp;
    logic [W_W-1:0]    wexp;
    beats  = int'(ax[12:5]) + 1;
    id     = ax[16:13];
    done   = 0;
    raised = 0;
    // Address phase, with a randomly stalling slave.
    for (int k = 0; k < 8 && !done; k++) begin
      tick();
      rdy = (k >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (g == 2'd3) s_awready = rdy; else s_arready = rdy;
      smp();
      if (k == 0) begin
        chk("grant", grant, g);
        chk("busy", busy, 1);
      end
      chk("s_axvalid", (g == 2'd3) ? s_awvalid : s_arvalid, 1);
      chk("s_axbus", (g == 2'd3) ? s_aw_bus : s_ar_bus, ax);
      chk("m_axready", axready(g), rdy);
      chk("other_quiet", other(g), 0);
      done = rdy;
    end
    // Master keeps its valid up one more cycle; the address must not reissue.
    tick();
    s_arready = 0; s_awready = 0;
    smp();
    chk("addr_once", {s_arvalid, s_awvalid}, 0);
    chk("grant_hold", grant, g);

    got = 0;
    if (g != 2'd3) begin
      for (int k = 0; k < 64 && got < beats; k++) begin
        tick();
        if (k == 0) begin
          if (g == 2'd1) begin m0_arvalid = 0; m0_rready = 1; end
          else           begin m1_arvalid = 0; m1_rready = 1; end
        end
        if (late && !raised && got >= ((beats > 1) ? 1 : 0)) begin
          m1_arvalid = 1;
          raised     = 1;
        end
        v = ($urandom_range(0, 3) != 0);
        d = dseed + DATA_W'(got);
        rexp = {d, resp, (got == beats - 1), id};
        s_rvalid = v;
        s_r_bus  = v ? rexp : '0;
        smp();
        chk("m_rvalid", (g == 2'd1) ? m0_rvalid : m1_rvalid, v);
        chk("s_rready", s_rready, 1);
        if (v) chk("m_rbus", (g == 2'd1) ? m0_r_bus : m1_r_bus, rexp);
        chk("grant_burst", grant, g);
        chk("other_quiet", other(g), 0);
        if (v) got++;
      end
      if (got < beats) chk("r_beats_timeout", got, beats);
    end else begin
      for (int k = 0; k < 32 && got < beats; k++) begin
        tick();
        if (k == 0) m1_awvalid = 0;
        wexp = {dseed + DATA_W'(got), strb, (got == beats - 1)};
        m1_wvalid = 1;
        m1_w_bus  = wexp;
        rdy = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        s_wready = rdy;
        smp();
        chk("s_wvalid", s_wvalid, 1);
        chk("s_wbus", s_w_bus, wexp);
        chk("m1_wready", m1_wready, rdy);
        chk("other_quiet", other(g), 0);
        if (rdy) got++;
      end
      if (got < beats) chk("w_beats_timeout", got, beats);
      tick();
      m1_wvalid = 0; m1_w_bus = '0; s_wready = 0;
      done = 0;
      for (int k = 0; k < 8 && !done; k++) begin
        if (k > 0) tick();
        v = (k >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        s_bvalid  = v;
        s_b_bus   = {resp, id};
        m1_bready = 1;
        smp();
        chk("m1_bvalid", m1_bvalid, v);
        chk("s_bready", s_bready, 1);
        if (v) chk("m1_bbus", m1_b_bus, {resp, id});
        chk("grant_wr", grant, g);
        done = v;
      end
    end
    // Final response taken: one idle cycle must follow.
    tick();
    s_rvalid = 0; s_r_bus = '0; s_bvalid = 0; s_b_bus = '0;
    m0_rready = 0; m1_rready = 0; m1_bready = 0;
    smp();
    chk("release", grant, 0);
    chk("idle_quiet", idle_vec(), 0);
  endtask

  // Raise a set of requests in one cycle and serve them in predicted order.
  task automatic round(input bit w1, input bit r1, input bit r0, input bit late,
                       input logic [AX_W-1:0] a0, input logic [AX_W-1:0] a1,
                       input logic [AX_W-1:0] aw, input logic [1:0] resp,
                       input logic [3:0] strb, input logic [DATA_W-1:0] dseed);
    int g;
    tick();
    m0_ar_bus = a0; m0_arvalid = r0;
    m1_ar_bus = a1; m1_arvalid = r1;
    m1_aw_bus = aw; m1_awvalid = w1;
    smp();
    chk("arb_latency", grant, 0);
    plan(w1, r1, r0);
    if (late) order.push_back(2);
    while (order.size() > 0) begin
      g = order.pop_front();
      run_txn(2'(g), (g == 1) ? a0 : (g == 2) ? a1 : aw, resp, strb,
              dseed + (DATA_W'(g) << 8), late && (g == 1));
      if (g == 1) last_rd_m = 1'b0;
      else if (g == 2) last_rd_m = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit w1, r1, r0, late;
    drive_idle_inputs();
    last_rd_m = 1'b0;
    rst = 1;
    repeat (3) @(posedge clk);
    smp();
    chk("reset_grant", grant, 0);
    chk("reset_quiet", idle_vec(), 0);
    tick();
    rst = 0;
    smp();
    chk("post_reset_grant", grant, 0);

    // Lone IFU fetch.
    round(0, 0, 1, 0, mk_ax(32'h3000_0000, 4'h1, 8'd0), '0, '0, 2'b00, 4'hF, 32'h1234_5678);
    // Reader tie.
    round(0, 1, 1, 0, mk_ax(32'h3000_0040, 4'h2, 8'd0), mk_ax(32'h8000_0100, 4'h3, 8'd1),
          '0, 2'b00, 4'hF, 32'h0000_1000);
    // Error response to the LSU still releases the grant.
    round(0, 1, 0, 0, '0, mk_ax(32'h8000_0200, 4'h4, 8'd0), '0, 2'b11, 4'hF, 32'hDEAD_0000);
    // Tie right after an M1 read: round-robin flips the order.
    round(0, 1, 1, 0, mk_ax(32'h3000_0080, 4'h5, 8'd0), mk_ax(32'h8000_0300, 4'h6, 8'd0),
          '0, 2'b00, 4'hF, 32'h0000_2000);
    // LSU write and read together, IFU also waiting.
    round(1, 1, 1, 0, mk_ax(32'h3000_00C0, 4'h7, 8'd0), mk_ax(32'h8000_0400, 4'h8, 8'd0),
          mk_ax(32'hA000_0010, 4'h9, 8'd0), 2'b00, 4'b0011, 32'h0000_3000);
    // IFU burst; LSU read arrives mid-burst and must wait for rlast.
    round(0, 0, 1, 1, mk_ax(32'hA000_0000, 4'hA, 8'd3), mk_ax(32'h8000_0500, 4'hB, 8'd0),
          '0, 2'b00, 4'hF, 32'h0000_4000);

    // Reset during the write data phase.
    tick();
    m1_aw_bus = mk_ax(32'hA000_0020, 4'hC, 8'd1); m1_awvalid = 1;
    smp();
    chk("rst_test_latency", grant, 0);
    tick();
    s_awready = 1;
    smp();
    chk("rst_test_grant", grant, 3);
    tick();
    m1_awvalid = 0; s_awready = 0;
    m1_wvalid = 1; m1_w_bus = {32'hCAFE_F00D, 4'hF, 1'b0};
    smp();
    chk("rst_test_wfwd", s_wvalid, 1);
    #2;
    rst = 1;
    #1;
    chk("rst_async_grant", grant, 0);
    chk("rst_async_quiet", idle_vec(), 0);
    drive_idle_inputs();
    last_rd_m = 1'b0;
    tick();
    rst = 0;
    round(0, 0, 1, 0, mk_ax(32'h3000_0100, 4'hD, 8'd1), '0, '0, 2'b00, 4'hF, 32'h0000_5000);

    // Randomized request mixes.
    for (int i = 0; i < 40; i++) begin
      w1 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      r0 = 1'($urandom_range(0, 1));
      if (!w1 && !r1 && !r0) r0 = 1;
      late = (r0 && !r1 && !w1) ? 1'($urandom_range(0, 1)) : 1'b0;
      round(w1, r1, r0, late,
            mk_ax($urandom, 4'($urandom), 8'($urandom_range(0, 3))),
            mk_ax($urandom, 4'($urandom), 8'($urandom_range(0, 3))),
            mk_ax($urandom, 4'($urandom), 8'($urandom_range(0, 3))),
            2'($urandom), 4'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
